// File: rtl/srf05_ranger_if.sv
// Signal bundle between the SRF05 ranger, the sensor pins and the flight-control consumer.
// The ranger itself connects through the slave modport.
interface srf05_ranger_if;
  logic        start;
  logic        echo;
  logic        trigger;
  logic [14:0] distance;
  logic        new_data;
  logic        out_of_range;
  logic        timeout;
  logic        error;
  logic        busy;

  modport master (
    output start, echo,
    input  trigger, distance, new_data, out_of_range, timeout, error, busy
  );

  modport slave (
    input  start, echo,
    output trigger, distance, new_data, out_of_range, timeout, error, busy
  );
endinterface

// File: rtl/srf05_ranger.sv
// SRF05 ultrasonic ranger: triggers the sensor, times the echo in microseconds and
// publishes distance with new_data / out_of_range / timeout strobes and a persistent error flag.
module srf05_ranger #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int TRIG_US      = 12,
  parameter int ECHO_WAIT_US = 2000,
  parameter int ECHO_MAX_US  = 30000,
  parameter int CYCLE_US     = 50000,
  parameter int MISS_LIMIT   = 3
) (
  input logic           clock,
  input logic           reset,
  srf05_ranger_if.slave bus
);

  localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [PW-1:0] PRESC_TC   = PW'(CLK_FREQ_MHZ - 1);
  localparam logic [15:0]   TRIG_LAST  = 16'(TRIG_US - 1);
  localparam logic [15:0]   WAIT_LAST  = 16'(ECHO_WAIT_US - 1);
  localparam logic [15:0]   ECHO_MAX   = 16'(ECHO_MAX_US);
  localparam logic [15:0]   CYCLE_LEN  = 16'(CYCLE_US);
  localparam logic [15:0]   CYCLE_LAST = 16'(CYCLE_US - 1);
  localparam logic [MW-1:0] MISS_MAX   = MW'(MISS_LIMIT);

  typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_ECHO, MEASURE, HOLDOFF} state_t;

  state_t        state;
  logic          echo_meta;
  logic          echo_s;
  logic [PW-1:0] presc;
  logic [PW-1:0] cyc_presc;
  logic [15:0]   phase_us;
  logic [15:0]   cycle_us;
  logic [MW-1:0] miss_cnt;
  logic          trigger;
  logic [14:0]   distance;
  logic          new_data;
  logic          out_of_range;
  logic          timeout;
  logic          error;
  logic          busy;

  logic us_tick;
  logic cyc_tick;
  logic cycle_done;
  logic go_trigger;

  assign bus.trigger      = trigger;
  assign bus.distance     = distance;
  assign bus.new_data     = new_data;
  assign bus.out_of_range = out_of_range;
  assign bus.timeout      = timeout;
  assign bus.error        = error;
  assign bus.busy         = busy;

  assign us_tick  = (presc == PRESC_TC);
  assign cyc_tick = (cyc_presc == PRESC_TC);

  // The period timer has its own prescaler so the restart at MEASURE entry cannot
  // stretch the trigger-to-trigger interval; it expires on the tick that completes CYCLE_US.
  assign cycle_done = (cycle_us >= CYCLE_LEN) || (cyc_tick && (cycle_us == CYCLE_LAST));
  assign go_trigger = bus.start && ((state == IDLE) || ((state == HOLDOFF) && cycle_done));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= bus.echo;
      echo_s    <= echo_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      cyc_presc    <= '0;
      phase_us     <= '0;
      cycle_us     <= '0;
      miss_cnt     <= '0;
      trigger      <= 1'b0;
      distance     <= '0;
      new_data     <= 1'b0;
      out_of_range <= 1'b0;
      timeout      <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      new_data     <= 1'b0;
      out_of_range <= 1'b0;
      timeout      <= 1'b0;
      error        <= (miss_cnt == MISS_MAX);

      if (state == IDLE) begin
        presc     <= '0;
        cyc_presc <= '0;
      end else begin
        presc     <= us_tick ? '0 : presc + 1'b1;
        cyc_presc <= cyc_tick ? '0 : cyc_presc + 1'b1;
        if (cyc_tick && (cycle_us != 16'hFFFF)) cycle_us <= cycle_us + 1'b1;
        if (us_tick && (phase_us != 16'hFFFF)) phase_us <= phase_us + 1'b1;
      end

      // Timed exits fire on the tick that would make phase_us reach its limit,
      // so trigger width and echo wait are exact multiples of a microsecond.
      case (state)
        IDLE: ;
        TRIGGER: begin
          if (us_tick && (phase_us == TRIG_LAST)) begin
            state    <= WAIT_ECHO;
            trigger  <= 1'b0;
            phase_us <= '0;
          end
        end
        WAIT_ECHO: begin
          if (echo_s) begin
            state    <= MEASURE;
            presc    <= '0;
            phase_us <= '0;
          end else if (us_tick && (phase_us == WAIT_LAST)) begin
            state    <= HOLDOFF;
            timeout  <= 1'b1;
            phase_us <= '0;
            if (miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (!echo_s) begin
            state    <= HOLDOFF;
            distance <= phase_us[14:0];
            new_data <= 1'b1;
            miss_cnt <= '0;
            phase_us <= '0;
          end else if (phase_us == ECHO_MAX) begin
            state        <= HOLDOFF;
            distance     <= ECHO_MAX[14:0];
            new_data     <= 1'b1;
            out_of_range <= 1'b1;
            miss_cnt     <= '0;
            phase_us     <= '0;
          end
        end
        HOLDOFF: begin
          if (cycle_done && !bus.start) begin
            state    <= IDLE;
            busy     <= 1'b0;
            phase_us <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (go_trigger) begin
        state     <= TRIGGER;
        trigger   <= 1'b1;
        busy      <= 1'b1;
        presc     <= '0;
        cyc_presc <= '0;
        cycle_us  <= '0;
        phase_us  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_srf05_ranger.sv
// Randomized bench for srf05_ranger: a sensor model answers each trigger with a planned
// echo (normal, missing or over-range) and a measurement-level model predicts the outcome.
module tb_srf05_ranger;

  localparam int CLK   = 2;
  localparam int TRIG  = 3;
  localparam int WAITU = 20;
  localparam int MAXU  = 60;
  localparam int CYC   = 100;
  localparam int MISS  = 3;
  localparam int WIN   = (CYC - TRIG) * CLK - 4;

  localparam int K_NORMAL = 0;
  localparam int K_NOECHO = 1;
  localparam int K_OVER   = 2;

  logic        clock = 1'b0;
  logic        reset;
  int unsigned cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  srf05_ranger_if bus ();

  srf05_ranger #(
    .CLK_FREQ_MHZ(CLK),
    .TRIG_US(TRIG),
    .ECHO_WAIT_US(WAITU),
    .ECHO_MAX_US(MAXU),
    .CYCLE_US(CYC),
    .MISS_LIMIT(MISS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int last_rise = 0;
  bit have_last = 0;
  bit fresh = 0;
  int rel_cyc = 0;
  int miss_model = 0;
  int dist_lo = 0;
  int dist_hi = 0;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] observed, input int lo, input int hi);
    checks++;
    assert ((observed >= lo) && (observed <= hi)) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_trigger"}, bus.trigger, 0);
    check_output({tag, "_distance"}, bus.distance, 0);
    check_output({tag, "_new_data"}, bus.new_data, 0);
    check_output({tag, "_out_of_range"}, bus.out_of_range, 0);
    check_output({tag, "_timeout"}, bus.timeout, 0);
    check_output({tag, "_error"}, bus.error, 0);
    check_output({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic wait_trigger_rise(output bit ok);
    ok = 0;
    for (int i = 0; i < 3 * CYC * CLK; i++) begin
      if (bus.trigger === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    check_output("trigger_rise_seen", ok, 1);
  endtask

  // One full measurement cycle: trigger, sensor response, then outcome against the model.
  task automatic apply_stimulus(input int kind, input int d, input int w, input bit stop_mid);
    bit ok;
    int tw = 0, nd_cnt = 0, to_cnt = 0, oor_cnt = 0, oor_with_nd = 0, repeats = 0;
    int nd_t = -1, to_t = -1, nd_dist = -1;
    logic p_nd = 0, p_to = 0, p_oor = 0;

    wait_trigger_rise(ok);
    if (!ok) return;
    if (have_last) check_output("trigger_period", cyc - last_rise, CYC * CLK);
    if (fresh) check_range("fresh_trigger_delay", cyc - rel_cyc, 1, 3);
    last_rise = cyc;
    have_last = 1;

    while ((bus.trigger === 1'b1) && (tw < 4 * TRIG * CLK)) begin
      tw++;
      @(negedge clock);
    end
    check_output("trigger_width", tw, TRIG * CLK);

    for (int t = 0; t < WIN; t++) begin
      if (bus.new_data === 1'b1) begin
        nd_cnt++;
        nd_t = t;
        nd_dist = int'(bus.distance);
        if (bus.out_of_range === 1'b1) oor_with_nd++;
      end
      if (bus.out_of_range === 1'b1) oor_cnt++;
      if (bus.timeout === 1'b1) begin
        to_cnt++;
        to_t = t;
      end
      if ((bus.new_data && p_nd) || (bus.timeout && p_to) || (bus.out_of_range && p_oor)) repeats++;
      p_nd  = bus.new_data;
      p_to  = bus.timeout;
      p_oor = bus.out_of_range;
      bus.echo = (kind != K_NOECHO) && (t >= d * CLK) && (t < (d + w) * CLK);
      if (stop_mid && (t == (d + w / 2) * CLK)) bus.start = 1'b0;
      @(negedge clock);
    end
    bus.echo = 1'b0;

    check_output("strobe_single_cycle", repeats, 0);
    if (kind == K_NORMAL) begin
      check_output("normal_new_data_count", nd_cnt, 1);
      check_output("normal_out_of_range_count", oor_cnt, 0);
      check_output("normal_timeout_count", to_cnt, 0);
      check_range("normal_distance", nd_dist, w - 1, w + 1);
      check_range("normal_latency", nd_t, (d + w) * CLK + 1, (d + w) * CLK + 4);
      miss_model = 0;
      dist_lo = w - 1;
      dist_hi = w + 1;
    end else if (kind == K_NOECHO) begin
      check_output("noecho_timeout_count", to_cnt, 1);
      check_output("noecho_new_data_count", nd_cnt, 0);
      check_output("noecho_timeout_time", to_t, WAITU * CLK);
      check_range("noecho_distance_held", bus.distance, dist_lo, dist_hi);
      miss_model = (miss_model < MISS) ? miss_model + 1 : MISS;
    end else begin
      check_output("over_new_data_count", nd_cnt, 1);
      check_output("over_oor_count", oor_cnt, 1);
      check_output("over_oor_with_new_data", oor_with_nd, 1);
      check_output("over_distance", nd_dist, MAXU);
      check_range("over_time", nd_t, (d + MAXU) * CLK, (d + MAXU + 1) * CLK + 4);
      miss_model = 0;
      dist_lo = MAXU;
      dist_hi = MAXU;
    end
    check_output("error_flag", bus.error, (miss_model == MISS) ? 1 : 0);
    check_output("busy_in_holdoff", bus.busy, 1);
  endtask

  task automatic random_measurement(input int kind);
    if (kind == K_NORMAL) apply_stimulus(K_NORMAL, $urandom_range(1, 15), $urandom_range(2, MAXU - 4), 0);
    else if (kind == K_NOECHO) apply_stimulus(K_NOECHO, 0, 0, 0);
    else apply_stimulus(K_OVER, $urandom_range(1, 15), $urandom_range(MAXU + 5, MAXU + 15), 0);
  endtask

  initial begin
    bit ok;
    int tw;
    int trig_seen;
    int kinds[9] = '{K_NORMAL, K_NORMAL, K_NOECHO, K_NOECHO, K_NOECHO, K_NOECHO, K_NORMAL, K_OVER, K_NORMAL};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.echo = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check_output("idle_busy", bus.busy, 0);
    check_output("idle_trigger", bus.trigger, 0);

    $display("[TB] directed and random measurement cycles");
    bus.start = 1'b1;
    foreach (kinds[i]) random_measurement(kinds[i]);
    for (int i = 0; i < 10; i++) random_measurement($urandom_range(0, 2));

    $display("[TB] stop during measurement");
    apply_stimulus(K_NORMAL, $urandom_range(1, 15), $urandom_range(10, 50), 1);
    for (int i = 0; i < 2 * CYC * CLK; i++) begin
      if (bus.busy === 1'b0) break;
      @(negedge clock);
    end
    check_output("stop_busy_fall_time", cyc - last_rise, CYC * CLK);
    trig_seen = 0;
    for (int i = 0; i < 2 * CYC * CLK; i++) begin
      if (bus.trigger === 1'b1) trig_seen++;
      @(negedge clock);
    end
    check_output("stop_no_trigger", trig_seen, 0);
    check_output("stop_busy_low", bus.busy, 0);
    have_last = 0;

    $display("[TB] asynchronous reset mid-measurement");
    bus.start = 1'b1;
    wait_trigger_rise(ok);
    tw = 0;
    while ((bus.trigger === 1'b1) && (tw < 4 * TRIG * CLK)) begin
      tw++;
      @(negedge clock);
    end
    for (int t = 0; t < (5 + 20) * CLK; t++) begin
      bus.echo = (t >= 5 * CLK);
      @(negedge clock);
    end
    check_output("busy_before_reset", bus.busy, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async");
    bus.echo = 1'b0;
    @(negedge clock);
    check_output("reset_hold_trigger", bus.trigger, 0);
    @(negedge clock);
    reset = 1'b0;
    rel_cyc = cyc;
    fresh = 1;
    have_last = 0;
    miss_model = 0;
    dist_lo = 0;
    dist_hi = 0;
    apply_stimulus(K_NORMAL, $urandom_range(1, 15), $urandom_range(2, MAXU - 4), 0);
    fresh = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srf05_ranger.md
Name: srf05_ranger

Overview:
- Drives the SRF05 ultrasonic range sensor: issues trigger pulses, times the echo pulse in microseconds, and publishes height readings with a one-cycle new-data strobe.
- Sits directly upstream of the flight-control initialization and control stages, which consume distance and new_data and drive start/reset.
- Also detects missing echoes and over-range echoes, and flags a persistent sensor fault.

Parameters:
CLK_FREQ_MHZ, 50, system clock in MHz; sets the prescaler terminal count for a 1 us tick.
TRIG_US, 12, trigger pulse width in microseconds.
ECHO_WAIT_US, 2000, maximum time from trigger end to echo rise.
ECHO_MAX_US, 30000, echo width at which the measurement saturates.
CYCLE_US, 50000, minimum interval between trigger rising edges.
MISS_LIMIT, 3, consecutive timeouts that raise error.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  level; while high, measurements repeat every CYCLE_US
echo  in  1  raw sensor echo pin, asynchronous
trigger  out  1  sensor trigger pin
distance  out  15  last valid echo width in us, unsigned
new_data  out  1  one-cycle strobe; distance updated this cycle
out_of_range  out  1  one-cycle strobe, coincident with new_data when saturated
timeout  out  1  one-cycle strobe; no echo rise within ECHO_WAIT_US
error  out  1  high while consecutive timeouts >= MISS_LIMIT
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: already decided, one clock; reset is asynchronous and active-high.
  - Reset values: trigger=0, distance=0, new_data=0, out_of_range=0, timeout=0, error=0, busy=0.
  - Reset also clears the sync flops, prescaler, counters, miss counter and state (IDLE).
- Echo sync: 2-flop synchronizer; the FSM uses only the second flop output (echo_s).
- Tick generation:
  - Prescaler counts 0..CLK_FREQ_MHZ-1 and emits a 1-cycle us_tick at the terminal count.
  - It is held at 0 in IDLE and restarted on entry to TRIGGER and on entry to MEASURE.
- Timers:
  - cycle_us (16 bit) clears on TRIGGER entry and increments on each us_tick in all non-IDLE states. It saturates and does not wrap.
  - phase_us (16 bit) clears on every state change and increments on us_tick.
- FSM:
  - IDLE: start=1 -> TRIGGER.
  - TRIGGER: trigger=1. When phase_us==TRIG_US -> WAIT_ECHO, and trigger drops the same cycle.
  - WAIT_ECHO:
    - echo_s=1 -> MEASURE.
    - Otherwise, when phase_us==ECHO_WAIT_US: timeout pulse, miss counter +1 (saturating at MISS_LIMIT), -> HOLDOFF. distance is unchanged.
    - If echo_s rises on the same cycle the limit is reached, echo wins and there is no timeout.
  - MEASURE:
    - echo_s=0: distance<=phase_us[14:0], new_data pulse, miss counter cleared, -> HOLDOFF.
    - phase_us==ECHO_MAX_US before the fall: distance<=ECHO_MAX_US, new_data and out_of_range pulse, miss counter cleared, -> HOLDOFF.
    - In the saturated case, the rest of the echo is ignored.
  - HOLDOFF: when cycle_us>=CYCLE_US, -> TRIGGER if start=1, else -> IDLE.
- error = (miss counter == MISS_LIMIT), registered. It clears in the cycle after a valid or saturated measurement.
- start deassert: the current cycle completes normally, including HOLDOFF. start is sampled only in IDLE and at HOLDOFF exit.
- Latency: new_data rises on the 3rd rising clock edge after the edge that first samples echo low at the pin. Measured width is within ±1 us of the true width.
- distance holds its value between updates. new_data, out_of_range and timeout are never high for more than one cycle.
- Reset mid-operation: all outputs return to reset values immediately, asynchronously. trigger must not glitch high on release.
- Glitch on echo during WAIT_ECHO shorter than 2 clocks: may be captured. No filtering is required beyond the synchronizer.

Test Plan:
- Basic measurement (CLK_FREQ_MHZ=50): start=1, echo rises 700 us after trigger falls and stays high 5800 us. Required: trigger high for 600 cycles, then distance=5800±1, exactly one new_data pulse, timeout=0.
- Period: start held for 3 cycles with echo 1000 us wide. Required: trigger rising edges exactly 2,500,000 clocks apart and 3 new_data pulses.
- Timeout and error:
  - Echo tied low, start=1: timeout pulses 2000 us after each trigger fall, with no new_data and distance held at its prior value.
  - error rises after the 3rd timeout.
  - A following 1000 us echo clears error and sets distance=1000.
- Over-range: echo held high for 35 ms. Required: distance=30000, new_data and out_of_range pulse together at 30000 us, and the next trigger still occurs 50000 us after the previous one.
- Stop: start dropped during MEASURE. Required: the measurement completes (new_data), busy falls at HOLDOFF end, and no further trigger occurs.
- Async reset: reset asserted mid-MEASURE between clock edges. Required: all outputs are 0 before the next edge. After release with start=1, the first trigger starts a fresh cycle.
